jtag_scan_master: RTL and testbench
===================================

# jtag_scan_master

Parametrised JTAG scan master that drives a 1149.1 TAP controller over TMS/TDI and captures TDO. It executes IR scans, variable-length DR scans up to `DR_MAX` bits, and TAP resets from a valid/ready command port, returning the captured data on a response port. It tracks the DUT TAP state with an internal mirror. It sits beside `jtag_intf` in the bench and future SoC debug paths, replacing hand-written TMS sequences.

## Interface
- `IR_LENGTH`, default `` `IR_LENGTH `` (4): instruction register length.
- `DR_MAX`, default 32: maximum DR scan length; sets the width of the data buses.
- `CNT_W`, default `$clog2(DR_MAX+1)`: width of the length field.

Ports:
- `tck_pad_i`  in  1  TCK; everything is clocked on its rising edge.
- `trst_pad_i`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command accepted when valid and ready are both high.
- `cmd_op_i`  in  2  operation: 0 = IR scan, 1 = DR scan, 2 = TAP reset, 3 = reserved (error).
- `cmd_len_i`  in  CNT_W  DR scan length; ignored for IR scans and resets.
- `cmd_data_i`  in  DR_MAX  TDI bits, shifted LSB first; an IR scan uses `[IR_LENGTH-1:0]`.
- `tms_o`  out  1  to `tms_pad_i`.
- `tdi_o`  out  1  to `tdi_pad_i`.
- `tdo_i`  in  1  from `tdo_pad_o`.
- `rsp_valid_o`  out  1  one-cycle completion pulse.
- `rsp_err_o`  out  1  qualifies `rsp_valid_o`; high for an illegal command.
- `rsp_data_o`  out  DR_MAX  captured TDO bits, LSB first; unused upper bits are 0.
- `tap_state_o`  out  4  mirrored TAP state (`tap_state_e`).

## Operation
- Reset values: `tms_o`=1, `tdi_o`=0, `cmd_ready_o`=0, `rsp_valid_o`=0, `rsp_err_o`=0, `rsp_data_o`=0, `tap_state_o`=TEST_LOGIC_RESET.
- Master FSM states: INIT, IDLE, PRE, SHIFT, POST, RST.
- INIT: drives `tms_o`=0 for one cycle so the mirror reaches RUN_TEST_IDLE, then moves to IDLE.
- IDLE: `cmd_ready_o`=1 and `tms_o`=0.
- After acceptance, the FSM presents one TMS/TDI pair per cycle.
- DR scan TMS sequence:
  - PRE: 1, 0, 0.
  - SHIFT: n bits; TMS is 0 except on the last bit, where it is 1.
  - POST: 1, 0.
- IR scan TMS sequence:
  - PRE: 1, 1, 0, 0.
  - SHIFT: `IR_LENGTH` bits, with the same last-bit rule.
  - POST: 1, 0.
- SHIFT: `tdi_o`=`cmd_data_i[k]` on shift bit k.
- TDO capture: `tdo_i` is sampled on every rising edge while `tap_state_o` is SHIFT_DR or SHIFT_IR, and stored at index k.
- RST: drives TMS=1 for 5 cycles, then 0 for 1 cycle.
- Illegal commands (op 3, DR length 0, or DR length > DR_MAX) are accepted but cause no TAP activity. `tms_o` stays 0. The FSM asserts `rsp_valid_o` and `rsp_err_o` on the next cycle.
- The command is latched on acceptance; later changes to `cmd_*` have no effect.
- The mirror applies the standard 16-state TMS transition to `tms_o` on every edge, so it always equals the DUT TAP state.
- `tdi_o`=0 outside SHIFT.
- `trst_pad_i` asserted mid-scan aborts the scan immediately: all outputs take their reset values, no response is produced, and the FSM restarts from INIT.

## Timing
- Latency, counted from the acceptance edge to the `rsp_valid_o` cycle:
  - DR scan: n+5 cycles.
  - IR scan: `IR_LENGTH`+6 cycles.
  - Reset: 6 cycles.
  - Error: 1 cycle.
- `rsp_valid_o` is high for exactly one cycle, when `tap_state_o`=RUN_TEST_IDLE. `cmd_ready_o` rises in the same cycle.
- Back-to-back: a command held valid is accepted in the `rsp_valid_o` cycle, so there is no idle cycle between scans.
- `rsp_data_o` holds its value until the next response.
- TDO is sampled on the rising edge; the DUT updates it on the falling edge, giving a half-cycle margin.

## Structure
- Package `jtag_pkg` contains:
  - `tap_state_e`, the 16 IEEE 1149.1 states with 4-bit encoding.
  - `jtag_op_e` {OP_IR, OP_DR, OP_RST, OP_RSVD}.
  - Instruction constants for EXTEST, SAMPLE_PRELOAD, IDCODE, DEBUG, MBIST, and BYPASS.
- Sub-module `jtag_tap_mirror`: the registered 16-state next-state logic. It takes `tms` and outputs `tap_state`, and is reusable by the bench scoreboard.
- The master FSM, bit counter, and shift/capture registers live in `jtag_scan_master`.

## Test plan
- Reset, then release `trst_pad_i`: 1 cycle with `tms_o`=0, after which `tap_state_o`=RUN_TEST_IDLE and `cmd_ready_o`=1.
- IR scan with `cmd_data_i`=4'h2 (IDCODE), then DR scan with len 32: `rsp_data_o`=32'h149511c3, `rsp_err_o`=0, and the DR scan completes 37 cycles after acceptance.
- IR scan with 4'hF (BYPASS), then DR scan with len 8 and data 8'hA5: `rsp_data_o`=8'h4A, and the TMS trace matches 1,0,0,0000000 1,1,0.
- DR scans with len 0 and with len 33: each produces a `rsp_valid_o`+`rsp_err_o` pulse 1 cycle later, with no change in `tms_o` or `tap_state_o`.
- `trst_pad_i` asserted low during bit 10 of a 32-bit DR scan: outputs take their reset values immediately, and no `rsp_valid_o` pulse appears.
- RST command followed immediately by an IR scan with `cmd_valid_i` held: the TMS sequence is 1,1,1,1,1,0, then the IR PRE sequence with no gap cycle.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG types: TAP states, command opcodes, master FSM states, instructions.
`ifndef IR_LENGTH
`define IR_LENGTH 4
`endif

package jtag_pkg;

   typedef enum logic [3:0] {
      TEST_LOGIC_RESET = 4'd0,
      RUN_TEST_IDLE    = 4'd1,
      SELECT_DR_SCAN   = 4'd2,
      CAPTURE_DR       = 4'd3,
      SHIFT_DR         = 4'd4,
      EXIT1_DR         = 4'd5,
      PAUSE_DR         = 4'd6,
      EXIT2_DR         = 4'd7,
      UPDATE_DR        = 4'd8,
      SELECT_IR_SCAN   = 4'd9,
      CAPTURE_IR       = 4'd10,
      SHIFT_IR         = 4'd11,
      EXIT1_IR         = 4'd12,
      PAUSE_IR         = 4'd13,
      EXIT2_IR         = 4'd14,
      UPDATE_IR        = 4'd15
   } tap_state_e;

   typedef enum logic [1:0] {
      OP_IR   = 2'd0,
      OP_DR   = 2'd1,
      OP_RST  = 2'd2,
      OP_RSVD = 2'd3
   } jtag_op_e;

   typedef enum logic [2:0] {
      M_INIT,
      M_IDLE,
      M_PRE,
      M_SHIFT,
      M_POST,
      M_RST
   } master_state_e;

   localparam logic [`IR_LENGTH-1:0] INSN_EXTEST         = `IR_LENGTH'('h0);
   localparam logic [`IR_LENGTH-1:0] INSN_SAMPLE_PRELOAD = `IR_LENGTH'('h1);
   localparam logic [`IR_LENGTH-1:0] INSN_IDCODE         = `IR_LENGTH'('h2);
   localparam logic [`IR_LENGTH-1:0] INSN_DEBUG          = `IR_LENGTH'('h8);
   localparam logic [`IR_LENGTH-1:0] INSN_MBIST          = `IR_LENGTH'('h9);
   localparam logic [`IR_LENGTH-1:0] INSN_BYPASS         = '1;

   // TMS held high this many cycles by a TAP reset, followed by one low cycle.
   localparam int unsigned RST_HIGH_CYCLES = 5;

endpackage

// File: rtl/jtag_tap_mirror.sv
// Registered IEEE 1149.1 TAP state machine driven by TMS.
module jtag_tap_mirror
   import jtag_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tms_i,
   output tap_state_e tap_state_o
);

   tap_state_e state_q, state_d;

   // Standard 16-state TMS transition table.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         TEST_LOGIC_RESET: state_d = tms_i ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
         RUN_TEST_IDLE:    state_d = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_DR_SCAN:   state_d = tms_i ? SELECT_IR_SCAN   : CAPTURE_DR;
         CAPTURE_DR:       state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
         SHIFT_DR:         state_d = tms_i ? EXIT1_DR         : SHIFT_DR;
         EXIT1_DR:         state_d = tms_i ? UPDATE_DR        : PAUSE_DR;
         PAUSE_DR:         state_d = tms_i ? EXIT2_DR         : PAUSE_DR;
         EXIT2_DR:         state_d = tms_i ? UPDATE_DR        : SHIFT_DR;
         UPDATE_DR:        state_d = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         SELECT_IR_SCAN:   state_d = tms_i ? TEST_LOGIC_RESET : CAPTURE_IR;
         CAPTURE_IR:       state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
         SHIFT_IR:         state_d = tms_i ? EXIT1_IR         : SHIFT_IR;
         EXIT1_IR:         state_d = tms_i ? UPDATE_IR        : PAUSE_IR;
         PAUSE_IR:         state_d = tms_i ? EXIT2_IR         : PAUSE_IR;
         EXIT2_IR:         state_d = tms_i ? UPDATE_IR        : SHIFT_IR;
         UPDATE_IR:        state_d = tms_i ? SELECT_DR_SCAN   : RUN_TEST_IDLE;
         default:          state_d = TEST_LOGIC_RESET;
      endcase
   end

   // State register; reset parks the mirror in Test-Logic-Reset like the TAP.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= TEST_LOGIC_RESET;
      else         state_q <= state_d;
   end

   assign tap_state_o = state_q;

endmodule

// File: rtl/jtag_scan_master.sv
// JTAG scan master: turns IR/DR/reset commands into TMS/TDI sequences and
// returns the TDO bits captured during the shift phase.
module jtag_scan_master
   import jtag_pkg::*;
#(
   parameter int unsigned IR_LENGTH = `IR_LENGTH,
   parameter int unsigned DR_MAX    = 32,
   parameter int unsigned CNT_W     = $clog2(DR_MAX + 1)
) (
   input  logic              tck_pad_i,
   input  logic              trst_pad_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [1:0]        cmd_op_i,
   input  logic [CNT_W-1:0]  cmd_len_i,
   input  logic [DR_MAX-1:0] cmd_data_i,
   output logic              tms_o,
   output logic              tdi_o,
   input  logic              tdo_i,
   output logic              rsp_valid_o,
   output logic              rsp_err_o,
   output logic [DR_MAX-1:0] rsp_data_o,
   output logic [3:0]        tap_state_o
);

   master_state_e      state_q;
   logic               tms_q, tdi_q, ready_q, rsp_valid_q, rsp_err_q;
   logic               err_q, is_ir_q;
   logic [DR_MAX-1:0]  rsp_data_q, data_q, cap_q;
   logic [CNT_W-1:0]   cnt_q, len_q;
   tap_state_e         tap_state;
   jtag_op_e           op_d;
   logic               bad_d, shift_d, finish_d;
   logic [CNT_W-1:0]   pre_last_d, shamt_d;

   jtag_tap_mirror u_mirror (
      .clk_i       (tck_pad_i),
      .rst_ni      (trst_pad_i),
      .tms_i       (tms_q),
      .tap_state_o (tap_state)
   );

   // Command decode, capture qualifier and end-of-command detection.
   always_comb begin
      op_d       = jtag_op_e'(cmd_op_i);
      bad_d      = (op_d == OP_RSVD) ||
                   ((op_d == OP_DR) && ((cmd_len_i == '0) || (cmd_len_i > CNT_W'(DR_MAX))));
      shift_d    = (tap_state == SHIFT_DR) || (tap_state == SHIFT_IR);
      pre_last_d = is_ir_q ? CNT_W'(3) : CNT_W'(2);
      shamt_d    = CNT_W'(DR_MAX) - len_q;
      finish_d   = ((state_q == M_POST) && (cnt_q == CNT_W'(1))) ||
                   ((state_q == M_RST) && (cnt_q == CNT_W'(RST_HIGH_CYCLES)));
   end

   // Master FSM with registered TMS/TDI, handshake and response outputs.
   always_ff @(posedge tck_pad_i or negedge trst_pad_i) begin
      if (!trst_pad_i) begin
         state_q     <= M_INIT;
         tms_q       <= 1'b1;
         tdi_q       <= 1'b0;
         ready_q     <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
         is_ir_q     <= 1'b0;
         data_q      <= '0;
         cap_q       <= '0;
         cnt_q       <= '0;
         len_q       <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         // TDO enters at the top and moves down; the response shift below
         // right-aligns the n captured bits so bit k is the k-th sample.
         if (shift_d) cap_q <= {tdo_i, cap_q[DR_MAX-1:1]};

         unique case (state_q)
            M_INIT: begin
               if (tms_q) begin
                  tms_q <= 1'b0;
               end else begin
                  state_q <= M_IDLE;
                  ready_q <= 1'b1;
               end
            end
            M_IDLE: begin
               if (cmd_valid_i && ready_q) begin
                  ready_q <= 1'b0;
                  data_q  <= cmd_data_i;
                  cap_q   <= '0;
                  cnt_q   <= '0;
                  is_ir_q <= (op_d == OP_IR);
                  len_q   <= (op_d == OP_IR) ? CNT_W'(IR_LENGTH) : cmd_len_i;
                  err_q   <= bad_d;
                  if (bad_d) begin
                     // Reuse the final POST step: TMS stays low, response next cycle.
                     state_q <= M_POST;
                     cnt_q   <= CNT_W'(1);
                  end else begin
                     tms_q   <= 1'b1;
                     state_q <= (op_d == OP_RST) ? M_RST : M_PRE;
                  end
               end
            end
            M_PRE: begin
               if (cnt_q == pre_last_d) begin
                  state_q <= M_SHIFT;
                  cnt_q   <= '0;
                  tms_q   <= (len_q == CNT_W'(1));
                  tdi_q   <= data_q[0];
                  data_q  <= data_q >> 1;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  tms_q <= is_ir_q && (cnt_q == '0);
               end
            end
            M_SHIFT: begin
               if (cnt_q == len_q - CNT_W'(1)) begin
                  state_q <= M_POST;
                  cnt_q   <= '0;
                  tms_q   <= 1'b1;
                  tdi_q   <= 1'b0;
               end else begin
                  cnt_q  <= cnt_q + CNT_W'(1);
                  tms_q  <= (cnt_q + CNT_W'(2) == len_q);
                  tdi_q  <= data_q[0];
                  data_q <= data_q >> 1;
               end
            end
            M_POST: begin
               if (cnt_q == '0) begin
                  cnt_q <= CNT_W'(1);
                  tms_q <= 1'b0;
               end
            end
            M_RST: begin
               if (cnt_q != CNT_W'(RST_HIGH_CYCLES)) begin
                  cnt_q <= cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(RST_HIGH_CYCLES - 1)) tms_q <= 1'b0;
               end
            end
            default: state_q <= M_INIT;
         endcase

         if (finish_d) begin
            state_q     <= M_IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err_q;
            rsp_data_q  <= cap_q >> shamt_d;
         end
      end
   end

   assign cmd_ready_o = ready_q;
   assign tms_o       = tms_q;
   assign tdi_o       = tdi_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_err_o   = rsp_err_q;
   assign rsp_data_o  = rsp_data_q;
   assign tap_state_o = tap_state;

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master with a behavioural TAP target
// (IDCODE + BYPASS registers) attached to the pads.
module tb_jtag_scan_master;
   import jtag_pkg::*;

   localparam logic [31:0] IDCODE_VAL = 32'h149511c3;

   logic        tck = 1'b0;
   logic        trst_pad_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic [1:0]  cmd_op_i;
   logic [5:0]  cmd_len_i;
   logic [31:0] cmd_data_i;
   logic        tms_o, tdi_o, tdo_i;
   logic        rsp_valid_o, rsp_err_o;
   logic [31:0] rsp_data_o;
   logic [3:0]  tap_state_o;

   int checks   = 0;
   int failures = 0;
   int rsp_cnt  = 0;

   always #5 tck = ~tck;

   jtag_scan_master #(.IR_LENGTH(4), .DR_MAX(32)) dut (
      .tck_pad_i   (tck),
      .trst_pad_i  (trst_pad_i),
      .cmd_valid_i (cmd_valid_i),
      .cmd_ready_o (cmd_ready_o),
      .cmd_op_i    (cmd_op_i),
      .cmd_len_i   (cmd_len_i),
      .cmd_data_i  (cmd_data_i),
      .tms_o       (tms_o),
      .tdi_o       (tdi_o),
      .tdo_i       (tdo_i),
      .rsp_valid_o (rsp_valid_o),
      .rsp_err_o   (rsp_err_o),
      .rsp_data_o  (rsp_data_o),
      .tap_state_o (tap_state_o)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural TAP target ----------------
   tap_state_e  tgt_q;
   logic [31:0] dr_q;
   logic [3:0]  ir_q, irsh_q;

   function automatic tap_state_e tgt_next(input tap_state_e s, input logic m);
      tap_state_e n;
      n = s;
      if (m) begin
         case (s)
            TEST_LOGIC_RESET, SELECT_IR_SCAN:          n = TEST_LOGIC_RESET;
            RUN_TEST_IDLE, UPDATE_DR, UPDATE_IR:       n = SELECT_DR_SCAN;
            SELECT_DR_SCAN:                            n = SELECT_IR_SCAN;
            CAPTURE_DR, SHIFT_DR:                      n = EXIT1_DR;
            EXIT1_DR, EXIT2_DR:                        n = UPDATE_DR;
            PAUSE_DR:                                  n = EXIT2_DR;
            CAPTURE_IR, SHIFT_IR:                      n = EXIT1_IR;
            EXIT1_IR, EXIT2_IR:                        n = UPDATE_IR;
            PAUSE_IR:                                  n = EXIT2_IR;
            default:                                   n = TEST_LOGIC_RESET;
         endcase
      end else begin
         case (s)
            TEST_LOGIC_RESET, RUN_TEST_IDLE, UPDATE_DR, UPDATE_IR: n = RUN_TEST_IDLE;
            SELECT_DR_SCAN:                            n = CAPTURE_DR;
            CAPTURE_DR, SHIFT_DR, EXIT2_DR:            n = SHIFT_DR;
            EXIT1_DR, PAUSE_DR:                        n = PAUSE_DR;
            SELECT_IR_SCAN:                            n = CAPTURE_IR;
            CAPTURE_IR, SHIFT_IR, EXIT2_IR:            n = SHIFT_IR;
            EXIT1_IR, PAUSE_IR:                        n = PAUSE_IR;
            default:                                   n = TEST_LOGIC_RESET;
         endcase
      end
      return n;
   endfunction

   always @(posedge tck or negedge trst_pad_i) begin
      if (!trst_pad_i) begin
         tgt_q  <= TEST_LOGIC_RESET;
         ir_q   <= INSN_IDCODE;
         irsh_q <= '0;
         dr_q   <= '0;
      end else begin
         tgt_q <= tgt_next(tgt_q, tms_o);
         case (tgt_q)
            TEST_LOGIC_RESET: ir_q <= INSN_IDCODE;
            CAPTURE_DR:       dr_q <= (ir_q == INSN_IDCODE) ? IDCODE_VAL : 32'h0;
            SHIFT_DR:         dr_q <= (ir_q == INSN_IDCODE) ? {tdi_o, dr_q[31:1]} : {31'h0, tdi_o};
            CAPTURE_IR:       irsh_q <= 4'b0001;
            SHIFT_IR:         irsh_q <= {tdi_o, irsh_q[3:1]};
            UPDATE_IR:        ir_q <= irsh_q;
            default: ;
         endcase
      end
   end

   always @(negedge tck) begin
      if (tgt_q == SHIFT_DR)      tdo_i <= dr_q[0];
      else if (tgt_q == SHIFT_IR) tdo_i <= irsh_q[0];
      else                        tdo_i <= 1'b0;
   end

   // Mirror must track the target TAP; TDI idles low outside shift states.
   always @(negedge tck) begin
      if (rsp_valid_o) rsp_cnt++;
      if (trst_pad_i) begin
         chk("mirror_state", 64'(tap_state_o), 64'(tgt_q));
         if (tgt_q != SHIFT_DR && tgt_q != SHIFT_IR) chk("tdi_idle", 64'(tdi_o), 64'd0);
      end
   end

   initial begin
      #50000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge tck);
      #1;
   endtask

   // Called just after the acceptance edge: records TMS per cycle until the response.
   task automatic wait_rsp(output int lat, output logic [63:0] tr);
      tr  = 64'(tms_o);
      lat = 0;
      while (lat < 100) begin
         tick();
         lat++;
         if (rsp_valid_o) break;
         tr = {tr[62:0], tms_o};
      end
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] data,
                          output int lat, output logic [63:0] tr);
      int guard;
      cmd_op_i    = op;
      cmd_len_i   = len;
      cmd_data_i  = data;
      cmd_valid_i = 1'b1;
      guard = 0;
      while (cmd_ready_o !== 1'b1 && guard < 100) begin
         tick();
         guard++;
      end
      chk("ready_before_cmd", 64'(cmd_ready_o), 64'd1);
      tick();
      cmd_valid_i = 1'b0;
      cmd_data_i  = ~data;
      cmd_len_i   = ~len;
      cmd_op_i    = 2'd3;
      wait_rsp(lat, tr);
   endtask

   int          lat;
   logic [63:0] tr;
   int          pulses;

   initial begin
      trst_pad_i  = 1'b0;
      cmd_valid_i = 1'b0;
      cmd_op_i    = 2'd0;
      cmd_len_i   = '0;
      cmd_data_i  = '0;
      repeat (3) tick();

      chk("rst_tms",       64'(tms_o),       64'd1);
      chk("rst_tdi",       64'(tdi_o),       64'd0);
      chk("rst_ready",     64'(cmd_ready_o), 64'd0);
      chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("rst_rsp_err",   64'(rsp_err_o),   64'd0);
      chk("rst_rsp_data",  64'(rsp_data_o),  64'd0);
      chk("rst_state",     64'(tap_state_o), 64'(TEST_LOGIC_RESET));

      trst_pad_i = 1'b1;
      tick();
      chk("init_tms",   64'(tms_o),       64'd0);
      chk("init_ready", 64'(cmd_ready_o), 64'd0);
      chk("init_state", 64'(tap_state_o), 64'(TEST_LOGIC_RESET));
      tick();
      chk("idle_state", 64'(tap_state_o), 64'(RUN_TEST_IDLE));
      chk("idle_ready", 64'(cmd_ready_o), 64'd1);

      // IR scan IDCODE: captured IR pattern is 0001
      run_cmd(2'd0, 6'd0, 32'h2, lat, tr);
      chk("ir_idcode_lat",   64'(lat),         64'd10);
      chk("ir_idcode_tms",   tr,               64'h306);
      chk("ir_idcode_err",   64'(rsp_err_o),   64'd0);
      chk("ir_idcode_data",  64'(rsp_data_o),  64'h1);
      chk("ir_idcode_state", 64'(tap_state_o), 64'(RUN_TEST_IDLE));
      chk("ir_idcode_ready", 64'(cmd_ready_o), 64'd1);

      // DR scan 32 bits reads the IDCODE
      run_cmd(2'd1, 6'd32, 32'h0, lat, tr);
      chk("dr32_lat",  64'(lat),        64'd37);
      chk("dr32_data", 64'(rsp_data_o), 64'h149511c3);
      chk("dr32_err",  64'(rsp_err_o),  64'd0);

      // BYPASS then 8-bit DR: A5 delayed by one bypass bit -> 4A
      run_cmd(2'd0, 6'd0, 32'hF, lat, tr);
      chk("ir_bypass_lat",  64'(lat),        64'd10);
      chk("ir_bypass_data", 64'(rsp_data_o), 64'h1);
      run_cmd(2'd1, 6'd8, 32'hA5, lat, tr);
      chk("dr8_lat",  64'(lat),        64'd13);
      chk("dr8_tms",  tr,              64'h1006);
      chk("dr8_data", 64'(rsp_data_o), 64'h4A);
      chk("dr8_err",  64'(rsp_err_o),  64'd0);

      // Abort a 32-bit DR scan during bit 10
      cmd_op_i    = 2'd1;
      cmd_len_i   = 6'd32;
      cmd_data_i  = 32'hDEADBEEF;
      cmd_valid_i = 1'b1;
      tick();
      cmd_valid_i = 1'b0;
      repeat (13) tick();
      chk("abort_pre_state", 64'(tap_state_o), 64'(SHIFT_DR));
      chk("abort_pre_ready", 64'(cmd_ready_o), 64'd0);
      pulses = rsp_cnt;
      trst_pad_i = 1'b0;
      #1;
      chk("abort_tms",       64'(tms_o),       64'd1);
      chk("abort_tdi",       64'(tdi_o),       64'd0);
      chk("abort_ready",     64'(cmd_ready_o), 64'd0);
      chk("abort_rsp_valid", 64'(rsp_valid_o), 64'd0);
      chk("abort_rsp_err",   64'(rsp_err_o),   64'd0);
      chk("abort_rsp_data",  64'(rsp_data_o),  64'd0);
      chk("abort_state",     64'(tap_state_o), 64'(TEST_LOGIC_RESET));
      repeat (2) tick();
      trst_pad_i = 1'b1;
      repeat (40) tick();
      chk("abort_no_rsp",     64'(rsp_cnt),     64'(pulses));
      chk("abort_reinit_st",  64'(tap_state_o), 64'(RUN_TEST_IDLE));
      chk("abort_reinit_rdy", 64'(cmd_ready_o), 64'd1);

      // Illegal commands: DR len 0, DR len 33, reserved op
      run_cmd(2'd1, 6'd0, 32'h5, lat, tr);
      chk("len0_lat",   64'(lat),         64'd1);
      chk("len0_err",   64'(rsp_err_o),   64'd1);
      chk("len0_tms",   tr,               64'd0);
      chk("len0_state", 64'(tap_state_o), 64'(RUN_TEST_IDLE));
      tick();
      chk("len0_pulse", 64'(rsp_valid_o), 64'd0);

      run_cmd(2'd1, 6'd33, 32'h5, lat, tr);
      chk("len33_lat",   64'(lat),         64'd1);
      chk("len33_err",   64'(rsp_err_o),   64'd1);
      chk("len33_tms",   tr,               64'd0);
      chk("len33_state", 64'(tap_state_o), 64'(RUN_TEST_IDLE));
      tick();
      chk("len33_pulse", 64'(rsp_valid_o), 64'd0);

      run_cmd(2'd3, 6'd8, 32'h5, lat, tr);
      chk("rsvd_lat", 64'(lat),       64'd1);
      chk("rsvd_err", 64'(rsp_err_o), 64'd1);
      tick();
      chk("rsvd_ready", 64'(cmd_ready_o), 64'd1);

      // TAP reset, then IR scan held valid: accepted in the response cycle
      cmd_op_i    = 2'd2;
      cmd_valid_i = 1'b1;
      tick();
      cmd_op_i   = 2'd0;
      cmd_data_i = 32'hF;
      cmd_len_i  = '0;
      wait_rsp(lat, tr);
      chk("rst_cmd_lat",   64'(lat),         64'd6);
      chk("rst_cmd_tms",   tr,               64'h3E);
      chk("rst_cmd_err",   64'(rsp_err_o),   64'd0);
      chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd1);
      chk("rst_cmd_state", 64'(tap_state_o), 64'(RUN_TEST_IDLE));
      tick();
      cmd_valid_i = 1'b0;
      cmd_data_i  = '0;
      chk("b2b_pulse_end", 64'(rsp_valid_o), 64'd0);
      chk("b2b_tms",       64'(tms_o),       64'd1);
      chk("b2b_ready",     64'(cmd_ready_o), 64'd0);
      wait_rsp(lat, tr);
      chk("b2b_ir_lat",  64'(lat),        64'd10);
      chk("b2b_ir_tms",  tr,              64'h306);
      chk("b2b_ir_data", 64'(rsp_data_o), 64'h1);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
